eth_fcs_insert: RTL and testbench



---
 rtl/eth_pkg.sv | 26 ++
 rtl/eth_crc32.sv | 26 ++
 rtl/eth_fcs_insert.sv | 154 +++++++++++++++
 tb/tb_eth_fcs_insert.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/eth_pkg.sv
// Shared Ethernet definitions: CRC-32 constants, minimum frame size, FCS-insert
// state encoding and the byte-wide reflected CRC-32 update function.
package eth_pkg;

    localparam logic [31:0] ETH_CRC32_POLY    = 32'hEDB88320;
    localparam logic [31:0] ETH_CRC32_INIT    = 32'hFFFFFFFF;
    localparam logic [31:0] ETH_CRC32_RESIDUE = 32'hDEBB20E3;
    localparam int          ETH_MIN_FRAME_BYTES = 60;

    typedef enum logic [1:0] {
        DATA = 2'd0,
        PAD  = 2'd1,
        FCS  = 2'd2
    } eth_fcs_state_t;

    // Reflected CRC-32: data bits are folded in LSB first.
    function automatic logic [31:0] crc32_update(input logic [31:0] crc, input logic [7:0] data);
        logic [31:0] c;
        c = crc ^ {24'h000000, data};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ ETH_CRC32_POLY) : (c >> 1);
        end
        return c;
    endfunction

endpackage

// File: rtl/eth_crc32.sv
// Byte-wide CRC-32 register shared by the transmit FCS inserter and the receive
// FCS checker; init takes priority over en.
module eth_crc32
    import eth_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        init,
    input  logic        en,
    input  logic [7:0]  data,
    output logic [31:0] crc
);

    logic [31:0] crc_q;

    always_ff @(posedge clk) begin
        if (reset || init) begin
            crc_q <= ETH_CRC32_INIT;
        end else if (en) begin
            crc_q <= crc32_update(crc_q, data);
        end
    end

    assign crc = crc_q;

endmodule

// File: rtl/eth_fcs_insert.sv
// Byte-wide AXI-Stream stage appending the Ethernet FCS to each frame. Zero-padding
// of short frames up to MIN_FRAME_BYTES is compiled in when ETH_FCS_PAD_EN is defined.
module eth_fcs_insert
    import eth_pkg::*;
#(
    parameter int MIN_FRAME_BYTES = ETH_MIN_FRAME_BYTES
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] s_axis_tdata,
    input  logic       s_axis_tvalid,
    output logic       s_axis_tready,
    input  logic       s_axis_tlast,
    output logic [7:0] m_axis_tdata,
    output logic       m_axis_tvalid,
    input  logic       m_axis_tready,
    output logic       m_axis_tlast
);

    eth_fcs_state_t state_q;
    logic [7:0]     data_q;
    logic           valid_q;
    logic           last_q;
    logic [1:0]     idx_q;

    logic           outFree;
    logic           inAccept;
    logic           crcInit;
    logic           crcEn;
    logic [7:0]     crcData;
    logic [31:0]    crcVal;
    logic [31:0]    fcsWord;
    logic [7:0]     fcsByte;
    logic           padNeeded;
    logic           padDone;

    if (MIN_FRAME_BYTES < 1 || MIN_FRAME_BYTES > 63) begin : g_minRangeError
        $error("eth_fcs_insert: MIN_FRAME_BYTES must be in 1..63");
    end

    assign outFree       = m_axis_tready | ~valid_q;
    assign s_axis_tready = (state_q == DATA) & outFree;
    assign inAccept      = s_axis_tvalid & s_axis_tready;

    assign fcsWord = ~crcVal;
    assign fcsByte = fcsWord[{idx_q, 3'b000} +: 8];

    always_comb begin
        crcInit = 1'b0;
        crcEn   = 1'b0;
        crcData = s_axis_tdata;
        case (state_q)
            DATA: crcEn = inAccept;
            PAD: begin
                crcEn   = outFree;
                crcData = 8'h00;
            end
            FCS: crcInit = outFree && (idx_q == 2'd3);
            default: crcInit = 1'b1;
        endcase
    end

    eth_crc32 u_crc (
        .clk   (clk),
        .reset (reset),
        .init  (crcInit),
        .en    (crcEn),
        .data  (crcData),
        .crc   (crcVal)
    );

`ifdef ETH_FCS_PAD_EN
    localparam logic [6:0] MIN7 = 7'(MIN_FRAME_BYTES);

    logic [5:0] count_q;
    logic [6:0] countInc;

    assign countInc  = {1'b0, count_q} + 7'd1;
    assign padNeeded = countInc < MIN7;
    assign padDone   = countInc >= MIN7;

    // count_q holds the number of bytes folded into the CRC, saturating at the minimum.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            case (state_q)
                DATA: if (inAccept && countInc <= MIN7) count_q <= countInc[5:0];
                PAD:  if (outFree) count_q <= countInc[5:0];
                FCS:  if (outFree && idx_q == 2'd3) count_q <= '0;
                default: count_q <= '0;
            endcase
        end
    end
`else
    assign padNeeded = 1'b0;
    assign padDone   = 1'b1;
`endif

    // The CRC restarts as the last FCS byte is loaded, so the next frame can enter
    // in the same cycle that byte is taken downstream.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= DATA;
            data_q  <= 8'h00;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            idx_q   <= 2'd0;
        end else begin
            case (state_q)
                DATA: begin
                    if (inAccept) begin
                        data_q  <= s_axis_tdata;
                        valid_q <= 1'b1;
                        last_q  <= 1'b0;
                        if (s_axis_tlast) begin
                            idx_q   <= 2'd0;
                            state_q <= padNeeded ? PAD : FCS;
                        end
                    end else if (m_axis_tready) begin
                        valid_q <= 1'b0;
                    end
                end
                PAD: begin
                    if (outFree) begin
                        data_q  <= 8'h00;
                        valid_q <= 1'b1;
                        last_q  <= 1'b0;
                        if (padDone) begin
                            state_q <= FCS;
                        end
                    end
                end
                FCS: begin
                    if (outFree) begin
                        data_q  <= fcsByte;
                        valid_q <= 1'b1;
                        last_q  <= (idx_q == 2'd3);
                        idx_q   <= idx_q + 2'd1;
                        if (idx_q == 2'd3) begin
                            state_q <= DATA;
                        end
                    end
                end
                default: state_q <= DATA;
            endcase
        end
    end

    assign m_axis_tdata  = data_q;
    assign m_axis_tvalid = valid_q;
    assign m_axis_tlast  = last_q;

endmodule

// File: tb/tb_eth_fcs_insert.sv
// Self-checking bench for eth_fcs_insert; follows ETH_FCS_PAD_EN like the design.
`timescale 1ns/1ps
module tb_eth_fcs_insert;

    localparam int MIN = 60;
`ifdef ETH_FCS_PAD_EN
    localparam bit PAD_ON = 1'b1;
`else
    localparam bit PAD_ON = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] s_axis_tdata;
    logic       s_axis_tvalid;
    logic       s_axis_tready;
    logic       s_axis_tlast;
    logic [7:0] m_axis_tdata;
    logic       m_axis_tvalid;
    logic       m_axis_tready;
    logic       m_axis_tlast;

    always #5 clk = ~clk;

    eth_fcs_insert #(.MIN_FRAME_BYTES(MIN)) dut (
        .clk           (clk),
        .reset         (reset),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .s_axis_tlast  (s_axis_tlast),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tlast  (m_axis_tlast)
    );

    int checks = 0;
    int errors = 0;

    byte unsigned inBytes[$];
    bit           inLast[$];
    byte unsigned expData[$];
    bit           expLast[$];
    byte unsigned outData[$];
    bit           outLast[$];
    int           outCycle[$];
    int           cycleCnt = 0;
    bit           randReady = 1'b0;

    typedef struct {
        int len;
        int outNoPad;
        int outPad;
    } vec_t;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Bit-serial reference CRC register (no final inversion) over a whole message.
    function automatic logic [31:0] refCrcReg(input byte unsigned msg[$]);
        logic [31:0] r;
        logic        fb;
        r = 32'hFFFFFFFF;
        foreach (msg[i]) begin
            for (int b = 0; b < 8; b++) begin
                fb = r[0] ^ msg[i][b];
                r  = r >> 1;
                if (fb) r = r ^ 32'hEDB88320;
            end
        end
        return r;
    endfunction

    // Queues one input frame and the wire frame the stage should produce for it.
    task automatic addFrame(input byte unsigned frame[$]);
        byte unsigned wireBytes[$];
        logic [31:0]  fcs;
        foreach (frame[i]) begin
            inBytes.push_back(frame[i]);
            inLast.push_back(i == frame.size() - 1);
        end
        wireBytes = frame;
        if (PAD_ON) begin
            while (wireBytes.size() < MIN) wireBytes.push_back(8'h00);
        end
        fcs = ~refCrcReg(wireBytes);
        for (int k = 0; k < 4; k++) wireBytes.push_back(fcs[8*k +: 8]);
        foreach (wireBytes[i]) begin
            expData.push_back(wireBytes[i]);
            expLast.push_back(i == wireBytes.size() - 1);
        end
    endtask

    task automatic applyStimulus(input int budget);
        int idx = 0;
        int cyc = 0;
        while (idx < inBytes.size()) begin
            s_axis_tdata  = inBytes[idx];
            s_axis_tlast  = inLast[idx];
            s_axis_tvalid = 1'b1;
            @(negedge clk);
            if (s_axis_tready) idx++;
            @(posedge clk);
            #1;
            cyc++;
            if (cyc > budget) begin
                checks++;
                errors++;
                $display("[TB] FAIL input_timeout: accepted %0d, required %0d bytes", idx, inBytes.size());
                break;
            end
        end
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
    endtask

    task automatic runStream(input string name, input int budget, input bit checkGap);
        int waitCycles = 0;
        int n;
        byte unsigned frameBuf[$];
        outData.delete();
        outLast.delete();
        outCycle.delete();
        applyStimulus(budget);
        while (outData.size() < expData.size() && waitCycles < budget) begin
            @(posedge clk);
            waitCycles++;
        end
        repeat (5) @(posedge clk);
        #1;
        checkOutput({name, " length"}, outData.size(), expData.size());
        n = (outData.size() < expData.size()) ? outData.size() : expData.size();
        for (int i = 0; i < n; i++) begin
            checkOutput($sformatf("%s data[%0d]", name, i), outData[i], expData[i]);
            checkOutput($sformatf("%s last[%0d]", name, i), outLast[i], expLast[i]);
        end
        foreach (outData[i]) begin
            frameBuf.push_back(outData[i]);
            if (outLast[i]) begin
                checkOutput({name, " residue"}, refCrcReg(frameBuf), 32'hDEBB20E3);
                frameBuf.delete();
            end
        end
        if (checkGap && outCycle.size() > 0) begin
            checkOutput({name, " cycles"}, outCycle[outCycle.size()-1] - outCycle[0] + 1, expData.size());
        end
        inBytes.delete();
        inLast.delete();
        expData.delete();
        expLast.delete();
    endtask

    always @(posedge clk) cycleCnt <= cycleCnt + 1;

    // Output monitor: records transfers and checks stability while stalled.
    logic [7:0] heldData;
    logic       heldLast;
    bit         holding = 1'b0;
    always @(negedge clk) begin
        if (reset) begin
            holding = 1'b0;
        end else begin
            if (holding) begin
                checkOutput("stall valid", m_axis_tvalid, 1'b1);
                checkOutput("stall data", m_axis_tdata, heldData);
                checkOutput("stall last", m_axis_tlast, heldLast);
            end
            if (m_axis_tvalid && m_axis_tready) begin
                outData.push_back(m_axis_tdata);
                outLast.push_back(m_axis_tlast);
                outCycle.push_back(cycleCnt);
                holding = 1'b0;
            end else if (m_axis_tvalid) begin
                holding  = 1'b1;
                heldData = m_axis_tdata;
                heldLast = m_axis_tlast;
            end else begin
                holding = 1'b0;
            end
        end
    end

    initial begin
        m_axis_tready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            m_axis_tready = randReady ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    initial begin
        #400us;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        byte unsigned frame[$];
        byte unsigned digits[$];
        vec_t vecs[7];
        int tgt;
        int n;

        vecs = '{'{9, 13, 64}, '{1, 5, 64}, '{59, 63, 64}, '{60, 64, 64},
                 '{61, 65, 65}, '{64, 68, 68}, '{100, 104, 104}};
        digits = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};

        reset         = 1'b1;
        s_axis_tdata  = 8'h00;
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        checkOutput("reset m_tvalid", m_axis_tvalid, 1'b0);
        checkOutput("reset m_tlast", m_axis_tlast, 1'b0);
        checkOutput("reset m_tdata", m_axis_tdata, 8'h00);
        checkOutput("reset s_tready", s_axis_tready, 1'b1);
        @(posedge clk);
        #1;

        // Known-answer frame "123456789"
        addFrame(digits);
        runStream("kat", 500, 1'b1);
        checkOutput("kat total", outData.size(), PAD_ON ? 64 : 13);
`ifdef ETH_FCS_PAD_EN
        for (int i = 9; i < 60 && i < outData.size(); i++) checkOutput("kat pad zero", outData[i], 8'h00);
`else
        if (outData.size() == 13) begin
            checkOutput("kat fcs0", outData[9], 8'h26);
            checkOutput("kat fcs1", outData[10], 8'h39);
            checkOutput("kat fcs2", outData[11], 8'hF4);
            checkOutput("kat fcs3", outData[12], 8'hCB);
            checkOutput("kat tlast", outLast[12], 1'b1);
        end
`endif

        // Table of frame lengths with expected output sizes, full throughput
        for (int v = 0; v < 7; v++) begin
            frame.delete();
            for (int i = 0; i < vecs[v].len; i++) frame.push_back(8'($urandom_range(0, 255)));
            addFrame(frame);
            runStream($sformatf("vec%0d", vecs[v].len), 1000, 1'b1);
            checkOutput($sformatf("vec%0d size", vecs[v].len), outData.size(),
                        PAD_ON ? vecs[v].outPad : vecs[v].outNoPad);
        end

        // Back-to-back random frames under 50% downstream backpressure
        randReady = 1'b1;
        for (int f = 0; f < 12; f++) begin
            frame.delete();
            n = (f % 3 == 0) ? 1 : ((f % 3 == 1) ? 64 : $urandom_range(1, 100));
            for (int i = 0; i < n; i++) frame.push_back(8'($urandom_range(0, 255)));
            addFrame(frame);
        end
        runStream("random", 8000, 1'b0);
        randReady = 1'b0;
        @(posedge clk);
        #1;

        // Reset while the second FCS byte sits in the output register
        addFrame(digits);
        expData.delete();
        expLast.delete();
        outData.delete();
        outLast.delete();
        applyStimulus(200);
        tgt = (PAD_ON ? MIN : 9) + 1;
        n = 0;
        while (outData.size() < tgt && n < 200) begin
            @(posedge clk);
            n++;
        end
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        checkOutput("abort m_tvalid", m_axis_tvalid, 1'b0);
        checkOutput("abort m_tlast", m_axis_tlast, 1'b0);
        checkOutput("abort s_tready", s_axis_tready, 1'b1);
        @(posedge clk);
        #1;
        inBytes.delete();
        inLast.delete();
        addFrame(digits);
        runStream("after reset", 500, 1'b1);
`ifndef ETH_FCS_PAD_EN
        if (outData.size() == 13) begin
            checkOutput("after reset fcs", {outData[12], outData[11], outData[10], outData[9]}, 32'hCBF43926);
        end
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
